arp_tx_sched: RTL and testbench

ARP_TX_SCHED -- requirements
Module: arp_tx_sched

---
 rtl/arp_tx_sched.sv | 192 +++++++++++++++++++
 tb/tb_arp_tx_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arp_tx_sched.sv
// ARP transmit scheduler: arbitrates pending replies and local resolution requests,
// then tracks the reply timeout. `define ARP_RETRY_EN enables request retransmission.
module arp_tx_sched #(
  parameter logic [31:0] TARGET_IP   = {8'd192, 8'd168, 8'd1, 8'd102},
  parameter logic [31:0] TIMEOUT_CYC = 32'd125_000_000,
  parameter int unsigned MAX_RETRY   = 32'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_trig_i,
  input  logic        rx_done_i,
  input  logic        rx_type_i,
  input  logic [47:0] rx_src_mac_i,
  input  logic [31:0] rx_src_ip_i,
  input  logic        tx_done_i,
  output logic        arp_tx_en_o,
  output logic        arp_tx_type_o,
  output logic [47:0] des_mac_o,
  output logic [31:0] des_ip_o,
  output logic        busy_o,
  output logic        resolved_valid_o,
  output logic [47:0] resolved_mac_o,
  output logic        arp_fail_o
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'b0001,
    S_LAUNCH     = 4'b0010,
    S_WAIT_DONE  = 4'b0100,
    S_WAIT_REPLY = 4'b1000
  } state_t;

  localparam logic [47:0] BCAST_MAC      = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [31:0] TIMEOUT_LAST_C = TIMEOUT_CYC - 32'd1;
  localparam logic [7:0]  RETRY_MAX_C    = 8'(MAX_RETRY);
`ifdef ARP_RETRY_EN
  localparam logic        RETRY_EN_C     = 1'b1;
`else
  localparam logic        RETRY_EN_C     = 1'b0;
`endif

  state_t      state_q;
  logic        arp_tx_en_q;
  logic        arp_tx_type_q;
  logic [47:0] des_mac_q;
  logic [31:0] des_ip_q;
  logic        resolved_valid_q;
  logic [47:0] resolved_mac_q;
  logic        arp_fail_q;
  logic        req_pend_q;
  logic        rep_pend_q;
  logic [47:0] buf_mac_q;
  logic [31:0] buf_ip_q;
  logic [31:0] timer_q;
  logic [31:0] timer_d;
  logic [7:0]  retry_cnt_q;
  // set while a resolution is outstanding, so a reply sent mid-wait returns to WAIT_REPLY
  logic        resolving_q;
  logic        timeout_s;
  logic        match_s;

  // saturating timer increment and reply/timeout decodes
  always_comb begin
    timer_d   = (timer_q == 32'hFFFF_FFFF) ? timer_q : (timer_q + 32'd1);
    timeout_s = (timer_q >= TIMEOUT_LAST_C);
    match_s   = rx_done_i && rx_type_i && (rx_src_ip_i == TARGET_IP);
  end

  // scheduler FSM, pending flags and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      arp_tx_en_q      <= 1'b0;
      arp_tx_type_q    <= 1'b0;
      des_mac_q        <= 48'd0;
      des_ip_q         <= 32'd0;
      resolved_valid_q <= 1'b0;
      resolved_mac_q   <= 48'd0;
      arp_fail_q       <= 1'b0;
      req_pend_q       <= 1'b0;
      rep_pend_q       <= 1'b0;
      buf_mac_q        <= 48'd0;
      buf_ip_q         <= 32'd0;
      timer_q          <= 32'd0;
      retry_cnt_q      <= 8'd0;
      resolving_q      <= 1'b0;
    end else begin
      arp_tx_en_q <= 1'b0;
      arp_fail_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rep_pend_q) begin
            arp_tx_en_q   <= 1'b1;
            arp_tx_type_q <= 1'b1;
            des_mac_q     <= buf_mac_q;
            des_ip_q      <= buf_ip_q;
            rep_pend_q    <= 1'b0;
            state_q       <= S_LAUNCH;
          end else if (req_pend_q) begin
            arp_tx_en_q   <= 1'b1;
            arp_tx_type_q <= 1'b0;
            des_mac_q     <= BCAST_MAC;
            des_ip_q      <= TARGET_IP;
            req_pend_q    <= 1'b0;
            retry_cnt_q   <= 8'd0;
            timer_q       <= 32'd0;
            resolving_q   <= 1'b1;
            state_q       <= S_LAUNCH;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LAUNCH: begin
          if (resolving_q) timer_q <= timer_d;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (resolving_q) timer_q <= timer_d;
          if (tx_done_i) begin
            if (!arp_tx_type_q) begin
              timer_q <= 32'd0;
              state_q <= S_WAIT_REPLY;
            end else if (resolving_q) begin
              state_q <= S_WAIT_REPLY;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_REPLY: begin
          timer_q <= timer_d;
          if (match_s) begin
            resolved_mac_q   <= rx_src_mac_i;
            resolved_valid_q <= 1'b1;
            resolving_q      <= 1'b0;
            state_q          <= S_IDLE;
          end else if (rep_pend_q) begin
            arp_tx_en_q   <= 1'b1;
            arp_tx_type_q <= 1'b1;
            des_mac_q     <= buf_mac_q;
            des_ip_q      <= buf_ip_q;
            rep_pend_q    <= 1'b0;
            state_q       <= S_LAUNCH;
          end else if (timeout_s) begin
            if (RETRY_EN_C && (retry_cnt_q < RETRY_MAX_C)) begin
              arp_tx_en_q   <= 1'b1;
              arp_tx_type_q <= 1'b0;
              des_mac_q     <= BCAST_MAC;
              des_ip_q      <= TARGET_IP;
              req_pend_q    <= 1'b0;
              retry_cnt_q   <= retry_cnt_q + 8'd1;
              timer_q       <= 32'd0;
              state_q       <= S_LAUNCH;
            end else begin
              arp_fail_q  <= 1'b1;
              resolving_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else begin
            state_q <= S_WAIT_REPLY;
          end
        end
        default: begin
          resolving_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
      // new events are recorded after the FSM so a same-cycle set beats a launch clear
      if (req_trig_i) begin
        req_pend_q       <= 1'b1;
        resolved_valid_q <= 1'b0;
      end
      if (rx_done_i && !rx_type_i) begin
        rep_pend_q <= 1'b1;
        buf_mac_q  <= rx_src_mac_i;
        buf_ip_q   <= rx_src_ip_i;
      end
    end
  end

  assign arp_tx_en_o      = arp_tx_en_q;
  assign arp_tx_type_o    = arp_tx_type_q;
  assign des_mac_o        = des_mac_q;
  assign des_ip_o         = des_ip_q;
  assign busy_o           = (state_q != S_IDLE);
  assign resolved_valid_o = resolved_valid_q;
  assign resolved_mac_o   = resolved_mac_q;
  assign arp_fail_o       = arp_fail_q;

endmodule

// File: tb/tb_arp_tx_sched.sv
// Scoreboard bench for arp_tx_sched: expected launches are queued when stimulus is
// driven and compared whenever the DUT pulses arp_tx_en.
module tb_arp_tx_sched;

  localparam logic [31:0] TGT_IP   = 32'hC0A8_0166;
  localparam logic [31:0] FOR_IP   = 32'hC0A8_0137;
  localparam logic [47:0] BCAST    = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] MAC_R    = 48'h02_11_22_33_44_55;
  localparam int          TIMEOUT  = 100;
  localparam int          TX_DLY   = 40;
  localparam int          GAP      = TX_DLY + TIMEOUT + 1;
`ifdef ARP_RETRY_EN
  localparam int          N_LAUNCH = 4;
`else
  localparam int          N_LAUNCH = 1;
`endif

  typedef struct packed {
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_trig = 1'b0;
  logic        rx_done = 1'b0;
  logic        rx_type = 1'b0;
  logic [47:0] rx_src_mac = 48'd0;
  logic [31:0] rx_src_ip = 32'd0;
  logic        tx_done = 1'b0;
  logic        arp_tx_en, arp_tx_type, busy, resolved_valid, arp_fail;
  logic [47:0] des_mac, resolved_mac;
  logic [31:0] des_ip;

  exp_t   exp_q[$];
  longint launch_t[$];
  longint cyc = 0;
  longint fail_t = 0;
  int     launch_cnt = 0;
  int     fail_cnt = 0;
  int     checks = 0;
  int     failures = 0;

  arp_tx_sched #(
    .TARGET_IP  (TGT_IP),
    .TIMEOUT_CYC(32'd100),
    .MAX_RETRY  (32'd3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_trig_i      (req_trig),
    .rx_done_i       (rx_done),
    .rx_type_i       (rx_type),
    .rx_src_mac_i    (rx_src_mac),
    .rx_src_ip_i     (rx_src_ip),
    .tx_done_i       (tx_done),
    .arp_tx_en_o     (arp_tx_en),
    .arp_tx_type_o   (arp_tx_type),
    .des_mac_o       (des_mac),
    .des_ip_o        (des_ip),
    .busy_o          (busy),
    .resolved_valid_o(resolved_valid),
    .resolved_mac_o  (resolved_mac),
    .arp_fail_o      (arp_fail)
  );

  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // launch scoreboard and fail-pulse monitor
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && arp_tx_en) begin
      launch_cnt++;
      launch_t.push_back(cyc);
      check_eq("launch_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("tx_type", 64'(arp_tx_type), 64'(e.typ));
        check_eq("des_mac", 64'(des_mac), 64'(e.mac));
        check_eq("des_ip", 64'(des_ip), 64'(e.ip));
      end
    end
    if (arp_fail) begin
      fail_cnt++;
      fail_t = cyc;
    end
  end

  // transmitter model: tx_done TX_DLY cycles after each launch, abandoned on reset
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && arp_tx_en) begin
        for (int k = 0; k < TX_DLY && rst_n; k++) @(negedge clk);
        if (rst_n) begin
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
        end
      end
    end
  end

  task automatic push_exp(input logic typ, input logic [47:0] mac, input logic [31:0] ip);
    exp_t e;
    e.typ = typ;
    e.mac = mac;
    e.ip  = ip;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req();
    @(negedge clk);
    req_trig = 1'b1;
    @(negedge clk);
    req_trig = 1'b0;
  endtask

  task automatic send_rx(input logic typ, input logic [47:0] mac, input logic [31:0] ip,
                         input logic with_req);
    @(negedge clk);
    rx_done    = 1'b1;
    rx_type    = typ;
    rx_src_mac = mac;
    rx_src_ip  = ip;
    req_trig   = with_req;
    @(negedge clk);
    rx_done  = 1'b0;
    req_trig = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_launches(input string tag, input int target, input int budget);
    int n = 0;
    while (launch_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(launch_cnt >= target), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_tx_en"}, 64'(arp_tx_en), 64'd0);
    check_eq({tag, "_tx_type"}, 64'(arp_tx_type), 64'd0);
    check_eq({tag, "_des_mac"}, 64'(des_mac), 64'd0);
    check_eq({tag, "_des_ip"}, 64'(des_ip), 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_rvalid"}, 64'(resolved_valid), 64'd0);
    check_eq({tag, "_rmac"}, 64'(resolved_mac), 64'd0);
    check_eq({tag, "_fail"}, 64'(arp_fail), 64'd0);
  endtask

  task automatic check_resolved(input string tag, input logic [47:0] mac);
    check_eq({tag, "_rvalid"}, 64'(resolved_valid), 64'd1);
    check_eq({tag, "_rmac"}, 64'(resolved_mac), 64'(mac));
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int base_l;
    int base_f;
    int base_i;
    #100000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_l;
    int base_f;
    int base_i;

    // reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // basic resolution and launch latency
    push_exp(1'b0, BCAST, TGT_IP);
    @(negedge clk);
    req_trig = 1'b1;
    @(negedge clk);
    req_trig = 1'b0;
    check_eq("launch_not_first_edge", 64'(arp_tx_en), 64'd0);
    @(negedge clk);
    check_eq("launch_second_edge", 64'(arp_tx_en), 64'd1);
    repeat (60) @(negedge clk);
    send_rx(1'b1, MAC_R, TGT_IP, 1'b0);
    check_resolved("basic", MAC_R);

    // foreign reply ignored, then timeout with or without retries
    base_l = launch_cnt;
    base_f = fail_cnt;
    base_i = launch_t.size();
    for (int i = 0; i < N_LAUNCH; i++) push_exp(1'b0, BCAST, TGT_IP);
    pulse_req();
    @(negedge clk);
    check_eq("rvalid_cleared_by_trig", 64'(resolved_valid), 64'd0);
    repeat (60) @(negedge clk);
    send_rx(1'b1, 48'h02_AA_BB_CC_DD_EE, FOR_IP, 1'b0);
    check_eq("foreign_rvalid", 64'(resolved_valid), 64'd0);
    check_eq("foreign_busy", 64'(busy), 64'd1);
    wait_idle("timeout_idle", 2000);
    check_eq("timeout_launches", 64'(launch_cnt - base_l), 64'(N_LAUNCH));
    check_eq("timeout_fail_pulses", 64'(fail_cnt - base_f), 64'd1);
    check_eq("fail_after_last_launch", 64'(fail_t - launch_t[launch_t.size() - 1]), 64'(GAP));
`ifdef ARP_RETRY_EN
    check_eq("retry_gap", 64'(launch_t[base_i + 1] - launch_t[base_i]), 64'(GAP));
`endif

    // simultaneous rx request and local trigger: reply first
    base_l = launch_cnt;
    push_exp(1'b1, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8_0109);
    push_exp(1'b0, BCAST, TGT_IP);
    send_rx(1'b0, 48'h0A_0B_0C_0D_0E_0F, 32'hC0A8_0109, 1'b1);
    wait_launches("both_launched", base_l + 2, 400);
    repeat (60) @(negedge clk);
    send_rx(1'b1, 48'h02_00_00_00_00_07, TGT_IP, 1'b0);
    check_resolved("after_pair", 48'h02_00_00_00_00_07);

    // reply launched from inside WAIT_REPLY returns to waiting
    push_exp(1'b0, BCAST, TGT_IP);
    pulse_req();
    repeat (60) @(negedge clk);
    push_exp(1'b1, 48'h06_05_04_03_02_01, 32'h0A00_0001);
    send_rx(1'b0, 48'h06_05_04_03_02_01, 32'h0A00_0001, 1'b0);
    repeat (50) @(negedge clk);
    check_eq("busy_after_excursion", 64'(busy), 64'd1);
    check_eq("rvalid_after_excursion", 64'(resolved_valid), 64'd0);
    send_rx(1'b1, MAC_R, TGT_IP, 1'b0);
    check_resolved("excursion", MAC_R);

    // reset in the middle of a frame, then a clean restart
    push_exp(1'b0, BCAST, TGT_IP);
    pulse_req();
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(1'b0, BCAST, TGT_IP);
    pulse_req();
    repeat (60) @(negedge clk);
    send_rx(1'b1, 48'h02_12_34_56_78_9A, TGT_IP, 1'b0);
    check_resolved("post_reset", 48'h02_12_34_56_78_9A);
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
